// File: rtl/spi_ram_responder.sv
// ---------------------------------------------------------------------------
// spi_ram_responder
//   SPI target (mode 0, MSB first) that emulates the external instruction RAM
//   read by the CPU's SPI fetch master. A frame is cmd[7:0], addr[15:0], then
//   data bytes. 0x03 reads and 0x02 writes; any other command is ignored until
//   chip select rises. All logic runs on clk, and the SPI pins are
//   oversampled through synchronisers.
//
// Parameters
//   ADDR_W       implemented address bits (DEPTH = 2**ADDR_W bytes)
//   SYNC_STAGES  synchroniser depth on spi_cs_n / spi_sck / spi_mosi (>= 2)
//
// Ports
//   clk, rst_n          system clock, synchronous active-low reset
//   spi_cs_n/sck/mosi   SPI inputs (asynchronous to clk)
//   spi_miso            SPI data out (driven low when not reading, never Z)
//   ld_we/ld_addr/ld_data  host preload write port
//   busy                a transaction is active
//   wr_pulse            one-cycle pulse per SPI byte written to memory
// ---------------------------------------------------------------------------
module spi_ram_responder #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              busy,
    output logic              wr_pulse
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_RD   = 3'd3,
        ST_WR   = 3'd4,
        ST_IGN  = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   cs_prev_r;
    logic                   sck_prev_r;
    logic                   cs_s;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   cs_fall_s;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [3:0]             bit_cnt_r;
    logic [2:0]             rd_cnt_r;
    logic [6:0]             sh_in_r;
    logic [6:0]             sh_out_r;
    logic [ADDR_W-1:0]      addr_r;
    logic                   is_rd_r;
    logic                   miso_r;
    logic                   busy_r;
    logic                   wr_pulse_r;

    logic [7:0]             mem [DEPTH];
    logic [7:0]             rx_byte_s;
    logic [7:0]             rd_byte_s;
    logic                   spi_we_s;

    assign cs_s      = cs_sync_r[SYNC_STAGES-1];
    assign sck_s     = sck_sync_r[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_r[SYNC_STAGES-1];
    assign rise_s    = sck_s & ~sck_prev_r;
    assign fall_s    = ~sck_s & sck_prev_r;
    assign cs_fall_s = cs_prev_r & ~cs_s;

    // Byte as it would look after shifting in the current mosi bit.
    assign rx_byte_s = {sh_in_r, mosi_s};
    assign rd_byte_s = mem[addr_r];
    assign spi_we_s  = rst_n & ~cs_s & (state_r == ST_WR) & rise_s & (bit_cnt_r == 4'd7);

    // Input synchronisers and edge-detect history. cs is reset to "low seen" so a
    // transfer already running when reset releases produces no falling edge and
    // is ignored until cs_n goes high and low again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_sync_r   <= {SYNC_STAGES{1'b0}};
            sck_sync_r  <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            cs_prev_r   <= 1'b0;
            sck_prev_r  <= 1'b0;
        end else begin
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], spi_sck};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            cs_prev_r   <= cs_s;
            sck_prev_r  <= sck_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; a deasserted chip select overrides every edge.
    always_comb begin
        state_next_s = state_r;
        if (cs_s) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_next_s = ST_CMD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (rise_s && (bit_cnt_r == 4'd7)) begin
                        if ((rx_byte_s == CMD_READ) || (rx_byte_s == CMD_WRITE)) begin
                            state_next_s = ST_ADDR;
                        end else begin
                            state_next_s = ST_IGN;
                        end
                    end else begin
                        state_next_s = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (rise_s && (bit_cnt_r == 4'd15)) begin
                        if (is_rd_r) begin
                            state_next_s = ST_RD;
                        end else begin
                            state_next_s = ST_WR;
                        end
                    end else begin
                        state_next_s = ST_ADDR;
                    end
                end
                ST_RD:   state_next_s = ST_RD;
                ST_WR:   state_next_s = ST_WR;
                ST_IGN:  state_next_s = ST_IGN;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Datapath: bit counters, shift registers, address and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_r  <= 4'd0;
            rd_cnt_r   <= 3'd0;
            sh_in_r    <= 7'd0;
            sh_out_r   <= 7'd0;
            addr_r     <= {ADDR_W{1'b0}};
            is_rd_r    <= 1'b0;
            miso_r     <= 1'b0;
            busy_r     <= 1'b0;
            wr_pulse_r <= 1'b0;
        end else begin
            wr_pulse_r <= spi_we_s;
            busy_r     <= (state_next_s != ST_IDLE);
            if (cs_s) begin
                bit_cnt_r <= 4'd0;
                rd_cnt_r  <= 3'd0;
                is_rd_r   <= 1'b0;
                miso_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        bit_cnt_r <= 4'd0;
                        rd_cnt_r  <= 3'd0;
                        miso_r    <= 1'b0;
                    end
                    ST_CMD: begin
                        miso_r <= 1'b0;
                        if (rise_s) begin
                            sh_in_r <= rx_byte_s[6:0];
                            if (bit_cnt_r == 4'd7) begin
                                bit_cnt_r <= 4'd0;
                                is_rd_r   <= (rx_byte_s == CMD_READ);
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        miso_r <= 1'b0;
                        // After 16 shifts the low ADDR_W bits hold addr[ADDR_W-1:0].
                        if (rise_s) begin
                            addr_r <= {addr_r[ADDR_W-2:0], mosi_s};
                            if (bit_cnt_r == 4'd15) begin
                                bit_cnt_r <= 4'd0;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end
                    ST_RD: begin
                        // Byte is captured from memory on its first falling edge,
                        // so later host loads cannot disturb the byte in flight.
                        if (fall_s) begin
                            if (rd_cnt_r == 3'd0) begin
                                miso_r   <= rd_byte_s[7];
                                sh_out_r <= rd_byte_s[6:0];
                                rd_cnt_r <= 3'd1;
                            end else begin
                                miso_r   <= sh_out_r[6];
                                sh_out_r <= {sh_out_r[5:0], 1'b0};
                                if (rd_cnt_r == 3'd7) begin
                                    rd_cnt_r <= 3'd0;
                                    addr_r   <= addr_r + ADDR_ONE;
                                end else begin
                                    rd_cnt_r <= rd_cnt_r + 3'd1;
                                end
                            end
                        end
                    end
                    ST_WR: begin
                        miso_r <= 1'b0;
                        if (rise_s) begin
                            sh_in_r <= rx_byte_s[6:0];
                            if (bit_cnt_r == 4'd7) begin
                                bit_cnt_r <= 4'd0;
                                addr_r    <= addr_r + ADDR_ONE;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end
                    ST_IGN: begin
                        miso_r <= 1'b0;
                    end
                    default: begin
                        miso_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Byte array with two write ports; not cleared by reset. An SPI write to the
    // same address in the same cycle takes priority over the host load.
    always_ff @(posedge clk) begin
        if (spi_we_s) begin
            mem[addr_r] <= rx_byte_s;
        end
        if (ld_we && !(spi_we_s && (ld_addr == addr_r))) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign spi_miso = miso_r;
    assign busy     = busy_r;
    assign wr_pulse = wr_pulse_r;

endmodule

// File: tb/tb_spi_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_ram_responder
//   Directed plus randomized bench for spi_ram_responder. A plain byte array
//   models the RAM; the SPI controller is bit-banged with long sck phases.
// ---------------------------------------------------------------------------
module tb_spi_ram_responder;

    localparam int ADDR_W = 8;
    localparam int H      = 6;   // clk periods per sck phase

    logic              clk = 1'b0;
    logic              rst_n;
    logic              spi_cs_n;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic              busy;
    logic              wr_pulse;

    logic [7:0] ref_mem [256];
    int n_chk  = 0;
    int n_pass = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    spi_ram_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .busy     (busy),
        .wr_pulse (wr_pulse)
    );

    always @(posedge clk) begin
        if (wr_pulse === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic [7:0] a, input logic [7:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            repeat (H) @(negedge clk);
            rx = {rx[6:0], spi_miso};
            spi_sck = 1'b1;
            repeat (H) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (H) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (H + 4) @(negedge clk);
    endtask

    task automatic hdr(input logic [7:0] cmd, input logic [15:0] a);
        logic [7:0] rx;
        xfer(cmd, 8, rx);
        xfer(a[15:8], 8, rx);
        xfer(a[7:0], 8, rx);
    endtask

    task automatic spi_write(input logic [15:0] a, input logic [7:0] d[$]);
        logic [7:0] rx;
        int w0;
        w0 = wr_cnt;
        cs_begin();
        chk("busy_in_write", 32'(busy), 32'd1);
        hdr(8'h02, a);
        foreach (d[i]) begin
            xfer(d[i], 8, rx);
            ref_mem[(int'(a[7:0]) + i) % 256] = d[i];
        end
        cs_end();
        chk("wr_pulse_count", 32'(wr_cnt - w0), 32'(d.size()));
        chk("busy_after_write", 32'(busy), 32'd0);
    endtask

    task automatic spi_read(input string tag, input logic [15:0] a, input int n);
        logic [7:0] rx;
        cs_begin();
        hdr(8'h03, a);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, 8, rx);
            chk(tag, 32'(rx), 32'(ref_mem[(int'(a[7:0]) + i) % 256]));
        end
        cs_end();
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] dq[$];
        int w0;

        rst_n = 1'b0; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        ld_we = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
        repeat (5) @(negedge clk);
        chk("rst_miso", 32'(spi_miso), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Fill the whole array with random contents so every read is defined.
        for (int i = 0; i < 256; i++) ld(8'(i), 8'($urandom));

        // 1: single byte read, known bit pattern.
        ld(8'h00, 8'h7A);
        cs_begin();
        hdr(8'h03, 16'h0000);
        xfer(8'h00, 8, rx);
        cs_end();
        chk("t1_read_7A", 32'(rx), 32'h7A);

        // 2: burst read across the top of the array.
        ld(8'hFE, 8'h11); ld(8'hFF, 8'h22); ld(8'h00, 8'h33);
        spi_read("t2_wrap_read", 16'h00FE, 3);

        // 3: two-byte write then read back.
        dq = '{8'hA5, 8'h3C};
        spi_write(16'h0010, dq);
        spi_read("t3_readback", 16'h0010, 2);

        // 4: unknown command is ignored entirely.
        w0 = wr_cnt;
        cs_begin();
        xfer(8'h9F, 8, rx);
        for (int i = 0; i < 3; i++) begin
            xfer(8'h55, 8, rx);
            chk("t4_miso_zero", 32'(rx), 32'h00);
        end
        cs_end();
        chk("t4_no_wr_pulse", 32'(wr_cnt - w0), 32'd0);
        spi_read("t4_mem_unchanged", 16'h0055, 2);

        // 5: partial data byte is discarded.
        ld(8'h20, 8'hC3);
        w0 = wr_cnt;
        cs_begin();
        hdr(8'h02, 16'h0020);
        xfer(8'h0F, 4, rx);
        cs_end();
        chk("t5_no_wr_pulse", 32'(wr_cnt - w0), 32'd0);
        spi_read("t5_partial", 16'h0020, 1);

        // 6: reset in the middle of a read data byte.
        ld(8'h40, 8'hFF); ld(8'h41, 8'h5A);
        cs_begin();
        hdr(8'h03, 16'h0040);
        xfer(8'h00, 3, rx);
        repeat (H) @(negedge clk);
        chk("t6_miso_before_rst", 32'(spi_miso), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_miso_rst", 32'(spi_miso), 32'd0);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        xfer(8'h00, 8, rx);
        chk("t6_ignored_miso", 32'(rx), 32'h00);
        chk("t6_ignored_busy", 32'(busy), 32'd0);
        cs_end();
        spi_read("t6_fresh_read", 16'h0040, 2);

        // Randomized writes and reads, including address wrap.
        for (int k = 0; k < 6; k++) begin
            logic [15:0] a;
            int n;
            a = 16'($urandom);
            if (k == 0) a[7:0] = 8'hFD;
            n = $urandom_range(1, 4);
            dq.delete();
            for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
            spi_write(a, dq);
            spi_read("rand_read", a, n + 1);
            spi_read("rand_read_other", 16'($urandom), 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
